uart_cmd_rx: RTL and testbench

Receive-side packet assembler for the host command link. It consumes the byte stream arriving on the UART_RX four-phase valid/ack handshake and assembles 9-byte command packets: one command byte, then op1 and op2, each 32 bits, MSB byte first. It presents each complete packet to the compute datapath on a valid/ready interface. It sits between the UART receive port of the wrapper and the command-execution logic.

---
 rtl/uart_cmd_pkg.sv | 29 ++
 rtl/uart_byte_hs_rx.sv | 50 +++++
 rtl/uart_cmd_rx.sv | 90 +++++++++
 tb/tb_uart_cmd_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the host command link: command codes, packet size,
// and the supported-command check used by the receiver and executor.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_SUB   = 8'h73;  // 's'
    localparam logic [7:0] CMD_DIV   = 8'h64;  // 'd'
    localparam logic [7:0] CMD_DIVU  = 8'h44;  // 'D'
    localparam logic [7:0] CMD_REM   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_REMU  = 8'h4D;  // 'M'
    localparam logic [7:0] CMD_MUL   = 8'h6D;  // 'm'
    localparam logic [7:0] CMD_MULH  = 8'h48;  // 'H'
    localparam logic [7:0] CMD_MULHU = 8'h68;  // 'h'

    localparam int unsigned PKT_BYTES = 9;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_t;

    function automatic logic is_known_cmd(input logic [7:0] code);
        case (code)
            CMD_SUB, CMD_DIV, CMD_DIVU, CMD_REM,
            CMD_REMU, CMD_MUL, CMD_MULH, CMD_MULHU: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_hs_rx.sv
// Four-phase valid/ack byte receiver: strobes one byte per handshake and
// refuses new bytes while the packet stage is holding a finished packet.
module uart_byte_hs_rx
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       hold,
    output logic       ack,
    output logic       byte_strobe,
    output logic [7:0] byte_data
);

    hs_state_t state;
    hs_state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        byte_strobe = 1'b0;
        case (state)
            HS_IDLE: begin
                if (rx_valid && !hold) begin
                    byte_strobe = 1'b1;
                    state_next  = HS_ACK;
                end
            end
            HS_ACK: begin
                if (!rx_valid) begin
                    state_next = HS_IDLE;
                end
            end
            default: state_next = HS_IDLE;
        endcase
    end

    // ack is a direct decode of the state flop, so it stays glitch-free
    assign ack       = (state == HS_ACK);
    assign byte_data = rx_data;

endmodule

// File: rtl/uart_cmd_rx.sv
// Assembles 9-byte command packets (code, op1, op2 MSB-first) from the UART
// byte handshake and presents them on a valid/ready interface.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  UART_RX,
    input  logic        UART_RX_valid,
    output logic        UART_RX_ack,
    output logic        CMD_valid,
    input  logic        CMD_ready,
    output logic [7:0]  CMD_code,
    output logic [31:0] CMD_op1,
    output logic [31:0] CMD_op2,
    output logic        CMD_known,
    output logic        CMD_drop
);

    logic        byte_strobe;
    logic [7:0]  byte_data;
    logic [3:0]  cnt;
    logic [63:0] sr;
    logic [31:0] tmo;
    logic        last_byte;
    logic        tmo_run;
    logic        tmo_hit;

    uart_byte_hs_rx u_hs (
        .clk        (CLK),
        .reset      (RESET),
        .rx_data    (UART_RX),
        .rx_valid   (UART_RX_valid),
        .hold       (CMD_valid),
        .ack        (UART_RX_ack),
        .byte_strobe(byte_strobe),
        .byte_data  (byte_data)
    );

    always_comb begin
        last_byte = (cnt == 4'(PKT_BYTES - 1));
        tmo_run   = (TIMEOUT_CYCLES != 0) && !UART_RX_ack && (cnt != 4'd0);
        tmo_hit   = tmo_run && (tmo == TIMEOUT_CYCLES - 32'd1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt       <= '0;
            sr        <= '0;
            tmo       <= '0;
            CMD_valid <= 1'b0;
            CMD_code  <= '0;
            CMD_op1   <= '0;
            CMD_op2   <= '0;
            CMD_known <= 1'b0;
            CMD_drop  <= 1'b0;
        end else begin
            CMD_drop <= 1'b0;
            if (CMD_valid && CMD_ready) begin
                CMD_valid <= 1'b0;
            end
            // byte 8 is taken straight from the handshake, never shifted in
            if (byte_strobe) begin
                tmo <= '0;
                if (last_byte) begin
                    cnt       <= '0;
                    CMD_code  <= sr[63:56];
                    CMD_op1   <= sr[55:24];
                    CMD_op2   <= {sr[23:0], byte_data};
                    CMD_known <= is_known_cmd(sr[63:56]);
                    CMD_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                    sr  <= {sr[55:0], byte_data};
                end
            end else if (tmo_hit) begin
                cnt      <= '0;
                tmo      <= '0;
                CMD_drop <= 1'b1;
            end else if (tmo_run) begin
                tmo <= tmo + 32'd1;
            end else begin
                tmo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: host-side byte handshakes with
// hand-computed packet contents, backpressure, timeout and reset cases.
module tb_uart_cmd_rx;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  UART_RX;
    logic        UART_RX_valid;
    logic        UART_RX_ack;
    logic        CMD_valid;
    logic        CMD_ready;
    logic [7:0]  CMD_code;
    logic [31:0] CMD_op1;
    logic [31:0] CMD_op2;
    logic        CMD_known;
    logic        CMD_drop;

    always #5 CLK = ~CLK;

    uart_cmd_rx #(.TIMEOUT_CYCLES(20)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .UART_RX      (UART_RX),
        .UART_RX_valid(UART_RX_valid),
        .UART_RX_ack  (UART_RX_ack),
        .CMD_valid    (CMD_valid),
        .CMD_ready    (CMD_ready),
        .CMD_code     (CMD_code),
        .CMD_op1      (CMD_op1),
        .CMD_op2      (CMD_op2),
        .CMD_known    (CMD_known),
        .CMD_drop     (CMD_drop)
    );

    int vectors     = 0;
    int miscompares = 0;

    int   cyc         = 0;
    int   ack_rises   = 0;
    int   valid_rises = 0;
    int   drop_count  = 0;
    int   drop_cyc    = 0;
    logic ack_d       = 1'b0;
    logic valid_d     = 1'b0;
    logic [72:0] pkt_q[$];

    // passive monitor: handshake edges, drop pulses and consumed packets
    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        ack_d   <= UART_RX_ack;
        valid_d <= CMD_valid;
        if (UART_RX_ack && !ack_d) ack_rises <= ack_rises + 1;
        if (CMD_valid && !valid_d) valid_rises <= valid_rises + 1;
        if (CMD_drop) begin
            drop_count <= drop_count + 1;
            drop_cyc   <= cyc;
        end
        if (CMD_valid && CMD_ready) pkt_q.push_back({CMD_code, CMD_op1, CMD_op2, CMD_known});
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        UART_RX       = b;
        UART_RX_valid = 1'b1;
        t = 0;
        while (UART_RX_ack !== 1'b1 && t < 200) begin
            tick(1);
            t++;
        end
        if (UART_RX_ack !== 1'b1) check("ack_rise_wait", UART_RX_ack, 1);
        UART_RX_valid = 1'b0;
        UART_RX       = ~b;
        t = 0;
        while (UART_RX_ack !== 1'b0 && t < 200) begin
            tick(1);
            t++;
        end
        if (UART_RX_ack !== 1'b0) check("ack_fall_wait", UART_RX_ack, 0);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic send_pkt(input logic [7:0] code, input logic [31:0] op1, input logic [31:0] op2);
        send_byte(code);
        send_word(op1);
        send_word(op2);
    endtask

    task automatic expect_pkt(input string tag, input logic [7:0] code, input logic [31:0] op1,
                              input logic [31:0] op2, input logic known);
        int t;
        logic [72:0] p;
        t = 0;
        while (pkt_q.size() == 0 && t < 100) begin
            tick(1);
            t++;
        end
        if (pkt_q.size() == 0) begin
            check({tag, "_missing"}, 0, 1);
        end else begin
            p = pkt_q.pop_front();
            check({tag, "_code"},  p[72:65], code);
            check({tag, "_op1"},   p[64:33], op1);
            check({tag, "_op2"},   p[32:1],  op2);
            check({tag, "_known"}, p[0],     known);
        end
    endtask

    int a0;
    int v0;
    int d0;
    int start;

    initial begin
        RESET         = 1'b1;
        UART_RX       = 8'h00;
        UART_RX_valid = 1'b0;
        CMD_ready     = 1'b0;
        tick(3);
        check("reset_outputs",
              {UART_RX_ack, CMD_valid, CMD_code, CMD_op1, CMD_op2, CMD_known, CMD_drop}, '0);
        RESET     = 1'b0;
        CMD_ready = 1'b1;
        tick(1);

        // basic packet with consumer always ready
        a0 = ack_rises;
        v0 = valid_rises;
        send_pkt(8'h73, 32'h0000_0009, 32'h0000_0005);
        expect_pkt("t1", 8'h73, 32'h0000_0009, 32'h0000_0005, 1'b1);
        check("t1_ack_count", ack_rises - a0, 9);
        check("t1_valid_rises", valid_rises - v0, 1);

        // backpressure: packet held, next host byte must stay un-acked
        CMD_ready = 1'b0;
        send_pkt(8'h72, 32'hFFFF_FFF2, 32'h0000_0003);
        UART_RX       = 8'h6D;
        UART_RX_valid = 1'b1;
        tick(50);
        check("t2_backpressure_ack", UART_RX_ack, 0);
        check("t2_hold_valid", CMD_valid, 1);
        check("t2_hold_fields", {CMD_code, CMD_op1, CMD_op2, CMD_known},
              {8'h72, 32'hFFFF_FFF2, 32'h0000_0003, 1'b1});
        CMD_ready = 1'b1;
        send_byte(8'h6D);
        send_word(32'h0000_0006);
        send_word(32'h0000_0007);
        expect_pkt("t2a", 8'h72, 32'hFFFF_FFF2, 32'h0000_0003, 1'b1);
        expect_pkt("t2b", 8'h6D, 32'h0000_0006, 32'h0000_0007, 1'b1);

        // partial packet abandoned, then a clean packet
        d0 = drop_count;
        send_byte(8'h73);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        start = cyc;
        tick(40);
        check("t3_drop_count", drop_count - d0, 1);
        check("t3_drop_delay", ((drop_cyc - start) >= 17) && ((drop_cyc - start) <= 24), 1);
        check("t3_no_stale_valid", CMD_valid, 0);
        send_pkt(8'h48, 32'h4000_0000, 32'h0000_0004);
        expect_pkt("t3", 8'h48, 32'h4000_0000, 32'h0000_0004, 1'b1);

        // unknown code is still delivered
        send_pkt(8'h78, 32'h0000_0001, 32'h0000_0002);
        expect_pkt("t4", 8'h78, 32'h0000_0001, 32'h0000_0002, 1'b0);

        // reset in the middle of a packet
        send_byte(8'h64);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        RESET = 1'b1;
        tick(1);
        check("t5_reset_outputs",
              {UART_RX_ack, CMD_valid, CMD_code, CMD_op1, CMD_op2, CMD_known, CMD_drop}, '0);
        RESET = 1'b0;
        tick(1);
        send_pkt(8'h68, 32'h8000_0000, 32'h0000_0002);
        expect_pkt("t5", 8'h68, 32'h8000_0000, 32'h0000_0002, 1'b1);

        // back-to-back packets at minimum host spacing
        a0 = ack_rises;
        send_pkt(8'h44, 32'h1234_5678, 32'h9ABC_DEF0);
        send_pkt(8'h4D, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_pkt("t6a", 8'h44, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        expect_pkt("t6b", 8'h4D, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        check("t6_ack_count", ack_rises - a0, 18);
        tick(2);
        check("t6_no_extra_pkt", pkt_q.size(), 0);
        check("total_drop_count", drop_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
